// File: rtl/dllp_rx_parser_if.sv
// ---------------------------------------------------------------------------
// dllp_rx_parser_if
// Receive AXI-Stream bundle carrying DLLP bytes from the physical layer.
//   tdata  : DLLP bytes, byte 0 in [7:0]
//   tkeep  : byte enables
//   tvalid : beat valid
//   tlast  : last beat of a DLLP
//   tuser  : [0] = PHY symbol/framing error on this beat
//   tready : sink ready
// master = PHY side (drives data), slave = parser side (drives tready).
// ---------------------------------------------------------------------------
interface dllp_rx_parser_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dllp_rx_parser.sv
// ---------------------------------------------------------------------------
// dllp_rx_parser
// Receive-side DLLP parser. Takes 6-byte DLLPs (4-byte body in beat 0, 16-bit
// CRC in beat 1), checks the DLLP CRC-16, decodes Ack/Nak and VC0 InitFC1/
// InitFC2/UpdateFC, and presents the results to the datalink transmit stage.
// Bad DLLPs are discarded and counted in a saturating error counter.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   s_axis              : receive stream (slave modport); never back-pressures
//   ack_nack_o          : 1 = Ack, 0 = Nak (qualified by ack_nack_vld_o)
//   ack_nack_vld_o      : one-cycle strobe for ack_nack_o/ack_seq_num_o
//   ack_seq_num_o       : AckNak_Seq_Num
//   tx_fc_*h_o          : latest header credits for P / NP / Cpl
//   tx_fc_*d_o          : latest data credits for P / NP / Cpl
//   fc_vld_o            : one-cycle strobe on any credit register update
//   fc_init_done_o      : sticky, P, NP and Cpl credits each seen once
//   err_cnt_o           : saturating count of discarded DLLPs
// ---------------------------------------------------------------------------
module dllp_rx_parser #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  dllp_rx_parser_if.slave s_axis,
  output logic            ack_nack_o,
  output logic            ack_nack_vld_o,
  output logic [11:0]     ack_seq_num_o,
  output logic [7:0]      tx_fc_ph_o,
  output logic [7:0]      tx_fc_nph_o,
  output logic [7:0]      tx_fc_cplh_o,
  output logic [11:0]     tx_fc_pd_o,
  output logic [11:0]     tx_fc_npd_o,
  output logic [11:0]     tx_fc_cpld_o,
  output logic            fc_vld_o,
  output logic            fc_init_done_o,
  output logic [7:0]      err_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CRC, ST_DROP} state_e;

  // DLLP CRC-16: poly 0x100B, seed 0xFFFF, bytes 0..3 fed LSB first, result
  // complemented. On the wire CRC bit 15 lands in byte 4 bit 0 and CRC bit 0
  // in byte 5 bit 7, i.e. {byte5, byte4} is the full 16-bit bit reversal.
  function automatic logic [15:0] crc_wire(input logic [31:0] body);
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      if (c[15] ^ body[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else                 c = {c[14:0], 1'b0};
    end
    c = ~c;
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  state_e      r_state;
  logic        r_tready;
  logic [31:0] r_body;
  logic [2:0]  r_seen;      // {Cpl, NP, P} credit types received
  logic        r_ack;
  logic        r_ack_vld;
  logic [11:0] r_seq;
  logic [7:0]  r_ph, r_nph, r_cplh;
  logic [11:0] r_pd, r_npd, r_cpld;
  logic        r_fc_vld;
  logic [7:0]  r_err;

  logic [DATA_WIDTH-1:0] w_data;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [USER_WIDTH-1:0] w_user;
  logic        w_last;
  logic        w_hs;
  logic [15:0] w_crc_exp;
  logic        w_good;
  logic        w_accept;
  logic        w_discard;
  logic        w_is_ack;
  logic        w_ack_type;
  logic [2:0]  w_fc_sel;
  logic [7:0]  w_hdr;
  logic [11:0] w_dfc;

  assign w_data    = s_axis.tdata;
  assign w_keep    = s_axis.tkeep;
  assign w_user    = s_axis.tuser;
  assign w_last    = s_axis.tlast;
  assign w_hs      = s_axis.tvalid & r_tready;
  assign w_crc_exp = crc_wire(r_body);

  // Only meaningful on the CRC beat; beat 0 is already in r_body.
  assign w_good = (w_keep == KEEP_WIDTH'(4'b0011)) && !w_user[0]
                  && (w_data[15:0] == w_crc_exp);

  // Any tlast handshake that is not a clean CRC-state finish ends a DLLP
  // that gets thrown away: single-beat, overlong, flagged or CRC failures.
  assign w_accept  = w_hs & w_last &  ((r_state == ST_CRC) & w_good);
  assign w_discard = w_hs & w_last & ~((r_state == ST_CRC) & w_good);

  // Field extraction: byte1 = body[15:8], byte2 = body[23:16], byte3 = body[31:24].
  assign w_hdr = {r_body[13:8], r_body[23:22]};
  assign w_dfc = {r_body[19:16], r_body[31:24]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    w_is_ack   = 1'b0;
    w_ack_type = 1'b0;
    w_fc_sel   = 3'b000;
    case (r_body[7:0])
      8'h00:               begin w_is_ack = 1'b1; w_ack_type = 1'b1; end
      8'h10:               w_is_ack = 1'b1;
      8'h40, 8'hC0, 8'h80: w_fc_sel = 3'b001;
      8'h50, 8'hD0, 8'h90: w_fc_sel = 3'b010;
      8'h60, 8'hE0, 8'hA0: w_fc_sel = 3'b100;
      default:             ;  // other types and non-VC0 FC are ignored
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_tready  <= 1'b0;
      r_body    <= '0;
      r_seen    <= '0;
      r_ack     <= 1'b0;
      r_ack_vld <= 1'b0;
      r_seq     <= '0;
      r_ph      <= '0;
      r_nph     <= '0;
      r_cplh    <= '0;
      r_pd      <= '0;
      r_npd     <= '0;
      r_cpld    <= '0;
      r_fc_vld  <= 1'b0;
      r_err     <= '0;
    end else begin
      r_tready  <= 1'b1;
      r_ack_vld <= w_accept & w_is_ack;
      r_fc_vld  <= w_accept & (|w_fc_sel);

      if (w_hs) begin
        case (r_state)
          ST_IDLE: begin
            r_body <= w_data[31:0];
            if (w_last)         r_state <= ST_IDLE;  // single-beat: counted now
            else if (w_user[0]) r_state <= ST_DROP;  // counted at its tlast
            else                r_state <= ST_CRC;
          end
          ST_CRC:  r_state <= w_last ? ST_IDLE : ST_DROP;
          ST_DROP: if (w_last) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_accept && w_is_ack) begin
        r_ack <= w_ack_type;
        r_seq <= w_dfc;
      end
      if (w_accept && w_fc_sel[0]) begin r_ph   <= w_hdr; r_pd   <= w_dfc; end
      if (w_accept && w_fc_sel[1]) begin r_nph  <= w_hdr; r_npd  <= w_dfc; end
      if (w_accept && w_fc_sel[2]) begin r_cplh <= w_hdr; r_cpld <= w_dfc; end
      r_seen <= r_seen | (w_accept ? w_fc_sel : 3'b000);

      if (w_discard && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  assign s_axis.tready  = r_tready;
  assign ack_nack_o     = r_ack;
  assign ack_nack_vld_o = r_ack_vld;
  assign ack_seq_num_o  = r_seq;
  assign tx_fc_ph_o     = r_ph;
  assign tx_fc_nph_o    = r_nph;
  assign tx_fc_cplh_o   = r_cplh;
  assign tx_fc_pd_o     = r_pd;
  assign tx_fc_npd_o    = r_npd;
  assign tx_fc_cpld_o   = r_cpld;
  assign fc_vld_o       = r_fc_vld;
  assign fc_init_done_o = &r_seen;
  assign err_cnt_o      = r_err;

endmodule

// File: tb/tb_dllp_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_dllp_rx_parser
// Self-checking bench for dllp_rx_parser. Expected Ack/Nak and credit events
// are queued as frames are sent and compared when the DUT strobes.
// ---------------------------------------------------------------------------
module tb_dllp_rx_parser;

  logic        clk_i;
  logic        rst_ni;
  logic        ack_nack_o;
  logic        ack_nack_vld_o;
  logic [11:0] ack_seq_num_o;
  logic [7:0]  tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o;
  logic [11:0] tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o;
  logic        fc_vld_o;
  logic        fc_init_done_o;
  logic [7:0]  err_cnt_o;

  dllp_rx_parser_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) axis ();

  dllp_rx_parser #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .s_axis         (axis),
    .ack_nack_o     (ack_nack_o),
    .ack_nack_vld_o (ack_nack_vld_o),
    .ack_seq_num_o  (ack_seq_num_o),
    .tx_fc_ph_o     (tx_fc_ph_o),
    .tx_fc_nph_o    (tx_fc_nph_o),
    .tx_fc_cplh_o   (tx_fc_cplh_o),
    .tx_fc_pd_o     (tx_fc_pd_o),
    .tx_fc_npd_o    (tx_fc_npd_o),
    .tx_fc_cpld_o   (tx_fc_cpld_o),
    .fc_vld_o       (fc_vld_o),
    .fc_init_done_o (fc_init_done_o),
    .err_cnt_o      (err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef enum logic {EV_ACK, EV_FC} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic        ack;
    logic [11:0] seq;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    logic        done;
  } ev_t;

  ev_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          fc_pulses = 0;
  logic [7:0]  m_err;
  logic [7:0]  m_ph, m_nph, m_cplh;
  logic [11:0] m_pd, m_npd, m_cpld;
  logic [2:0]  m_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // Returns {byte5, byte4} for a body {byte3, byte2, byte1, byte0}.
  function automatic logic [15:0] model_crc(input logic [31:0] body);
    logic [15:0] lfsr;
    logic [15:0] inv;
    lfsr = 16'hFFFF;
    for (int n = 0; n < 4; n++) begin
      logic [7:0] byt;
      byt = body[8*n +: 8];
      for (int k = 0; k < 8; k++) begin
        logic fb;
        fb   = lfsr[15] ^ byt[k];
        lfsr = {lfsr[14:0], 1'b0};
        if (fb) lfsr = lfsr ^ 16'h100B;
      end
    end
    inv = ~lfsr;
    return {rev8(inv[7:0]), rev8(inv[15:8])};
  endfunction

  function automatic logic [31:0] ack_body(input logic nak, input logic [11:0] seq);
    logic [7:0] b0, b1, b2, b3;
    b0 = nak ? 8'h10 : 8'h00;
    b1 = 8'($urandom);
    b2 = {4'($urandom), seq[11:8]};
    b3 = seq[7:0];
    return {b3, b2, b1, b0};
  endfunction

  // cls: 0=P 1=NP 2=Cpl; typ: 0=InitFC1 1=InitFC2 2=UpdateFC
  function automatic logic [31:0] fc_body(input logic [1:0] cls, input logic [1:0] typ,
                                          input logic [7:0] hdr, input logic [11:0] dat);
    logic [3:0] hi;
    logic [7:0] b1, b2;
    case (typ)
      2'd0:    hi = 4'h4 + {2'b00, cls};
      2'd1:    hi = 4'hC + {2'b00, cls};
      default: hi = 4'h8 + {2'b00, cls};
    endcase
    b1 = {2'($urandom), hdr[7:2]};
    b2 = {hdr[1:0], 2'($urandom), dat[11:8]};
    return {dat[7:0], b2, b1, hi, 4'h0};
  endfunction

  task automatic err_inc();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic expect_ack(input logic is_ack, input logic [11:0] seq);
    ev_t e;
    e      = '0;
    e.kind = EV_ACK;
    e.ack  = is_ack;
    e.seq  = seq;
    sb.push_back(e);
  endtask

  task automatic expect_fc(input logic [1:0] cls, input logic [7:0] hdr, input logic [11:0] dat);
    ev_t e;
    case (cls)
      2'd0:    begin m_ph   = hdr; m_pd   = dat; end
      2'd1:    begin m_nph  = hdr; m_npd  = dat; end
      default: begin m_cplh = hdr; m_cpld = dat; end
    endcase
    m_seen[cls] = 1'b1;
    e      = '0;
    e.kind = EV_FC;
    e.ph   = m_ph;  e.nph = m_nph;  e.cplh = m_cplh;
    e.pd   = m_pd;  e.npd = m_npd;  e.cpld = m_cpld;
    e.done = &m_seen;
    sb.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic u, input bit bub);
    if (bub && ($urandom_range(0, 3) == 0)) begin
      int n;
      n = int'($urandom_range(1, 2));
      axis.tvalid = 1'b0;
      repeat (n) begin
        axis.tdata = $urandom;
        axis.tlast = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
      end
    end
    axis.tdata  = d;
    axis.tkeep  = k;
    axis.tlast  = l;
    axis.tuser  = u;
    axis.tvalid = 1'b1;
    @(posedge clk_i); #1;
    axis.tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] body, input logic [15:0] flip,
                            input logic [3:0] keep1, input logic u0, input logic u1,
                            input bit bub);
    logic [15:0] crc;
    crc = model_crc(body) ^ flip;
    send_beat(body, 4'hF, 1'b0, u0, bub);
    send_beat({16'($urandom), crc}, keep1, 1'b1, u1, bub);
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk_i);
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(m_err));
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"},  32'(axis.tready),     32'd0);
    check({tag, "_ack"},     32'(ack_nack_o),      32'd0);
    check({tag, "_ack_vld"}, 32'(ack_nack_vld_o),  32'd0);
    check({tag, "_seq"},     32'(ack_seq_num_o),   32'd0);
    check({tag, "_ph"},      32'(tx_fc_ph_o),      32'd0);
    check({tag, "_nph"},     32'(tx_fc_nph_o),     32'd0);
    check({tag, "_cplh"},    32'(tx_fc_cplh_o),    32'd0);
    check({tag, "_pd"},      32'(tx_fc_pd_o),      32'd0);
    check({tag, "_npd"},     32'(tx_fc_npd_o),     32'd0);
    check({tag, "_cpld"},    32'(tx_fc_cpld_o),    32'd0);
    check({tag, "_fc_vld"},  32'(fc_vld_o),        32'd0);
    check({tag, "_done"},    32'(fc_init_done_o),  32'd0);
    check({tag, "_err"},     32'(err_cnt_o),       32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (rst_ni && (ack_nack_vld_o || fc_vld_o)) begin
      if (fc_vld_o) fc_pulses++;
      check("dual_strobe", 32'(ack_nack_vld_o & fc_vld_o), 32'd0);
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        check("strobe_kind", 32'(fc_vld_o), 32'(e.kind == EV_FC));
        if (e.kind == EV_ACK) begin
          check("ack_nack", 32'(ack_nack_o), 32'(e.ack));
          check("ack_seq",  32'(ack_seq_num_o), 32'(e.seq));
        end else begin
          check("fc_ph",   32'(tx_fc_ph_o),     32'(e.ph));
          check("fc_nph",  32'(tx_fc_nph_o),    32'(e.nph));
          check("fc_cplh", 32'(tx_fc_cplh_o),   32'(e.cplh));
          check("fc_pd",   32'(tx_fc_pd_o),     32'(e.pd));
          check("fc_npd",  32'(tx_fc_npd_o),    32'(e.npd));
          check("fc_cpld", 32'(tx_fc_cpld_o),   32'(e.cpld));
          check("fc_done", 32'(fc_init_done_o), 32'(e.done));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] body;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = '0;
    m_err = '0; m_seen = '0;
    m_ph = '0; m_nph = '0; m_cplh = '0; m_pd = '0; m_npd = '0; m_cpld = '0;

    // Reset state
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("tready_after_reset", 32'(axis.tready), 32'd1);

    // Ack, seq 0x123, bytes 00 00 01 23
    expect_ack(1'b1, 12'h123);
    send_frame(32'h2301_0000, 16'h0000, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("ack");
    check("ack_hold", 32'(ack_nack_o), 32'd1);

    // Nak seq 0xFFF, then the same frame with one CRC bit flipped
    body = ack_body(1'b1, 12'hFFF);
    expect_ack(1'b0, 12'hFFF);
    send_frame(body, 16'h0000, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("nak");
    send_frame(body, 16'h0100, 4'b0011, 1'b0, 1'b0, 1'b0);
    err_inc();
    settle("nak_badcrc");
    check("nak_seq_hold", 32'(ack_seq_num_o), 32'hFFF);

    // InitFC1 P / NP / Cpl
    expect_fc(2'd0, 8'h20, 12'h100);
    send_frame(fc_body(2'd0, 2'd0, 8'h20, 12'h100), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("fc_p");
    check("fc_done_after_p", 32'(fc_init_done_o), 32'd0);
    expect_fc(2'd1, 8'h10, 12'h040);
    send_frame(fc_body(2'd1, 2'd0, 8'h10, 12'h040), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("fc_np");
    check("fc_done_after_np", 32'(fc_init_done_o), 32'd0);
    expect_fc(2'd2, 8'h00, 12'h000);
    send_frame(fc_body(2'd2, 2'd0, 8'h00, 12'h000), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("fc_cpl");
    check("fc_done_after_cpl", 32'(fc_init_done_o), 32'd1);
    check("fc_pulse_count", 32'(fc_pulses), 32'd3);

    // Malformed framing, each followed by a recovering Ack
    body = ack_body(1'b0, 12'h001);
    send_beat(body, 4'hF, 1'b1, 1'b0, 1'b0);
    err_inc();
    expect_ack(1'b1, 12'h00A);
    send_frame(ack_body(1'b0, 12'h00A), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("single_beat");

    send_beat(body, 4'hF, 1'b0, 1'b0, 1'b0);
    send_beat({16'h0000, model_crc(body)}, 4'b0011, 1'b0, 1'b0, 1'b0);
    send_beat(32'h0, 4'b0011, 1'b1, 1'b0, 1'b0);
    err_inc();
    expect_ack(1'b1, 12'h00B);
    send_frame(ack_body(1'b0, 12'h00B), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("three_beat");

    send_frame(body, 16'h0, 4'b0011, 1'b0, 1'b1, 1'b0);
    err_inc();
    expect_ack(1'b1, 12'h00C);
    send_frame(ack_body(1'b0, 12'h00C), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("tuser_beat1");

    send_frame(body, 16'h0, 4'b0001, 1'b0, 1'b0, 1'b0);
    err_inc();
    expect_ack(1'b1, 12'h00D);
    send_frame(ack_body(1'b0, 12'h00D), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("keep_0001");

    // Back-to-back stress: 1 in 8 frames good, the rest bad in assorted ways
    for (int i = 0; i < 300; i++) begin
      logic        nk;
      logic [11:0] sq;
      logic [1:0]  cls, typ;
      logic [7:0]  h;
      logic [31:0] sb_body;
      nk  = 1'($urandom_range(0, 1));
      sq  = 12'($urandom);
      cls = 2'($urandom_range(0, 2));
      typ = 2'($urandom_range(0, 2));
      h   = 8'($urandom);
      if (i % 8 == 0) begin
        case ($urandom_range(0, 3))
          0: begin
            expect_ack(!nk, sq);
            send_frame(ack_body(nk, sq), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b1);
          end
          1: begin
            expect_fc(cls, h, sq);
            send_frame(fc_body(cls, typ, h, sq), 16'h0, 4'b0011, 1'b0, 1'b0, 1'b1);
          end
          2:       send_frame({sq[7:0], h, 8'h00, 8'h81}, 16'h0, 4'b0011, 1'b0, 1'b0, 1'b1);
          default: send_frame({sq[7:0], h, 8'h00, 8'h31}, 16'h0, 4'b0011, 1'b0, 1'b0, 1'b1);
        endcase
      end else begin
        sb_body = h[0] ? ack_body(nk, sq) : fc_body(cls, typ, h, sq);
        case ($urandom_range(0, 5))
          0: send_frame(sb_body, 16'(1) << $urandom_range(0, 15), 4'b0011, 1'b0, 1'b0, 1'b1);
          1: send_frame(sb_body, 16'h0, h[1] ? 4'b0001 : 4'b1111, 1'b0, 1'b0, 1'b1);
          2: send_frame(sb_body, 16'h0, 4'b0011, 1'b0, 1'b1, 1'b1);
          3: send_frame(sb_body, 16'h0, 4'b0011, 1'b1, 1'b0, 1'b1);
          4: send_beat(sb_body, 4'hF, 1'b1, 1'b0, 1'b1);
          default: begin
            send_beat(sb_body, 4'hF, 1'b0, 1'b0, 1'b1);
            send_beat({16'h0000, model_crc(sb_body)}, 4'b0011, 1'b0, 1'b0, 1'b1);
            send_beat(32'($urandom), 4'b0011, 1'b1, 1'b0, 1'b1);
          end
        endcase
        err_inc();
      end
    end
    settle("stress");
    check("stress_saturated", 32'(err_cnt_o), 32'hFF);
    check("stress_ph",   32'(tx_fc_ph_o),     32'(m_ph));
    check("stress_nph",  32'(tx_fc_nph_o),    32'(m_nph));
    check("stress_cplh", 32'(tx_fc_cplh_o),   32'(m_cplh));
    check("stress_pd",   32'(tx_fc_pd_o),     32'(m_pd));
    check("stress_npd",  32'(tx_fc_npd_o),    32'(m_npd));
    check("stress_cpld", 32'(tx_fc_cpld_o),   32'(m_cpld));
    check("stress_done", 32'(fc_init_done_o), 32'(&m_seen));

    // Reset between beat 0 and beat 1
    body = ack_body(1'b0, 12'h0AB);
    send_beat(body, 4'hF, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_all_zero("midreset");
    m_err = '0; m_seen = '0;
    m_ph = '0; m_nph = '0; m_cplh = '0; m_pd = '0; m_npd = '0; m_cpld = '0;
    sb.delete();
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_beat({16'h0000, model_crc(body)}, 4'b0011, 1'b1, 1'b0, 1'b0);
    err_inc();
    settle("orphan_beat1");
    expect_ack(1'b1, 12'h0AB);
    send_frame(body, 16'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    settle("post_reset_ack");
    check("post_reset_seq", 32'(ack_seq_num_o), 32'h0AB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
